// File: rtl/div_unit_pkg.sv
// Shared encodings and small decode helpers for the iterative RV32M divider.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'b00,
        DIV_ST_CALC = 2'b01,
        DIV_ST_FIN  = 2'b10
    } div_st_e;

    // funct3[0] clear means a signed operation (DIV/REM)
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Applies RISC-V sign rules to the unsigned quotient/remainder and selects the result.
module div_sign_fix
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] rem,
    input  logic            sign_a,
    input  logic            sign_b,
    input  logic [1:0]      op,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    // Sign flags are only ever set for signed ops, so unsigned ops pass through
    assign quo_fix = (sign_a ^ sign_b) ? (~quo + 1'b1) : quo;
    assign rem_fix = sign_a ? (~rem + 1'b1) : rem;
    assign result  = op_is_rem(op) ? rem_fix : quo_fix;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with start/done handshake and kill.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    div_st_e         state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]      op_q;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvsr;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] fix_out;

    logic            in_signed;
    logic            in_sa;
    logic            in_sb;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            ovf;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            finish;

    assign in_signed = op_is_signed(op_i);
    assign in_sa     = in_signed & dividend_i[XLEN-1];
    assign in_sb     = in_signed & divisor_i[XLEN-1];
    assign abs_a     = in_sa ? (~dividend_i + 1'b1) : dividend_i;
    assign abs_b     = in_sb ? (~divisor_i + 1'b1) : divisor_i;
    assign div_zero  = (divisor_i == '0);
    assign ovf       = in_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);

    // Partial remainder stays below the divisor, so a clear borrow bit means shifted >= divisor
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, dvsr};

    // A kill in the FIN cycle suppresses both the pulse and the result update
    assign finish   = (state == DIV_ST_FIN) && !kill_i;
    assign busy_o   = (state != DIV_ST_IDLE);
    assign done_o   = finish;
    assign result_o = finish ? fix_out : result_q;

    div_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .quo    (quo),
        .rem    (rem),
        .sign_a (sign_a),
        .sign_b (sign_b),
        .op     (op_q),
        .result (fix_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DIV_ST_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            result_q <= '0;
        end else begin
            case (state)
                DIV_ST_IDLE: begin
                    if (start_i && !kill_i) begin
                        op_q <= op_i;
                        dvsr <= abs_b;
                        if (div_zero || ovf) begin
                            // Special results are preloaded raw; clearing the flags keeps sign fix out
                            sign_a <= 1'b0;
                            sign_b <= 1'b0;
                            quo    <= div_zero ? '1 : dividend_i;
                            rem    <= div_zero ? dividend_i : '0;
                            state  <= DIV_ST_FIN;
                        end else begin
                            sign_a <= in_sa;
                            sign_b <= in_sb;
                            quo    <= abs_a;
                            rem    <= '0;
                            cnt    <= CNT_W'(XLEN - 1);
                            state  <= DIV_ST_CALC;
                        end
                    end
                end
                DIV_ST_CALC: begin
                    if (kill_i) begin
                        state <= DIV_ST_IDLE;
                    end else begin
                        if (!diff[XLEN]) begin
                            rem <= diff[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= shifted[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b0};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state <= DIV_ST_FIN;
                        end
                    end
                end
                DIV_ST_FIN: begin
                    if (!kill_i) begin
                        result_q <= fix_out;
                    end
                    state <= DIV_ST_IDLE;
                end
                default: state <= DIV_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, sign rules, special cases, kill and reset.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            kill_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int n_tests = 0;
    int n_fail  = 0;

    div_unit #(.XLEN(XLEN), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .kill_i     (kill_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start is sampled at edge 0; cycle c is the interval after edge c, sampled at its negedge.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int glitch_cyc);
        int lat;
        int busy_bad;
        @(negedge clk);
        check_eq({tag, "_idle_busy"}, {31'd0, busy_o}, 32'd0);
        check_eq({tag, "_idle_done"}, {31'd0, done_o}, 32'd0);
        op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        lat = 0;
        busy_bad = 0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            if (!busy_o) busy_bad++;
            if (done_o) lat = c;
            if (glitch_cyc != 0 && c == glitch_cyc - 1) begin
                op_i = DIV_OP_DIV; dividend_i = 32'd9; divisor_i = 32'd3; start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_result"}, result_o, exp);
        check_eq({tag, "_busy_gaps"}, busy_bad, 0);
    endtask

    initial begin
        logic [31:0] prev;
        int          saw_done;

        rst_n = 1'b0; start_i = 1'b0; kill_i = 1'b0;
        op_i = 2'b00; dividend_i = '0; divisor_i = '0;
        #12;
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_done", {31'd0, done_o}, 32'd0);
        check_eq("rst_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("div_m7_2",   DIV_OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, 0);
        run_op("rem_m7_2",   DIV_OP_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, 0);
        run_op("div_7_m2",   DIV_OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0);
        run_op("rem_7_m2",   DIV_OP_REM,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33, 0);
        run_op("divu_max_2", DIV_OP_DIVU, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF, 33, 0);
        run_op("remu_max_2", DIV_OP_REMU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 33, 0);
        run_op("div_by0",    DIV_OP_DIV,  32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1, 0);
        run_op("remu_by0",   DIV_OP_REMU, 32'h00001234, 32'h00000000, 32'h00001234, 1, 0);
        run_op("rem_neg_by0", DIV_OP_REM, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1, 0);
        run_op("div_min_by0", DIV_OP_DIV, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 1, 0);
        run_op("div_ovf",    DIV_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_op("rem_ovf",    DIV_OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0);
        run_op("divu_noovf", DIV_OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 0);
        run_op("remu_noovf", DIV_OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0);

        // Kill mid-CALC: no pulse, result held, idle the following cycle
        @(negedge clk);
        prev = result_o;
        op_i = DIV_OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        saw_done = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done_o) saw_done++;
            if (c == 10) kill_i = 1'b1;
        end
        check_eq("kill_busy_before", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        kill_i = 1'b0;
        check_eq("kill_busy_after", {31'd0, busy_o}, 32'd0);
        check_eq("kill_no_done", saw_done + int'(done_o), 0);
        check_eq("kill_result_held", result_o, prev);

        run_op("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
        run_op("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);

        // Start pulsed while busy must be ignored; the next op goes back-to-back
        run_op("div_50_5_glitch", DIV_OP_DIV, 32'd50, 32'd5, 32'd10, 33, 5);
        run_op("div_9_3_b2b",     DIV_OP_DIV, 32'd9,  32'd3, 32'd3,  33, 0);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        op_i = DIV_OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int c = 1; c <= 20; c++) @(negedge clk);
        check_eq("pre_arst_busy", {31'd0, busy_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("arst_done", {31'd0, done_o}, 32'd0);
        check_eq("arst_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("remu_after_rst", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits in the EX stage beside the ALU. Decode routes OP-opcode instructions with funct7=0000001 and funct3[2]=1 here, and the pipeline stalls while busy_o is high.
- Takes one operation at a time and uses a start/done handshake.
- Supports kill from a branch or jump flush.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request a new operation; sampled only in IDLE.
- op_i  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  input  XLEN  rs1 value, sampled with start_i.
- divisor_i  input  XLEN  rs2 value, sampled with start_i.
- kill_i  input  1  abort the in-flight operation (pipeline flush).
- busy_o  output  1  high whenever state != IDLE.
- done_o  output  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  output  XLEN  quotient or remainder, registered, held until the next done.

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, busy_o=0, done_o=0, result_o=0, all internal registers 0.
- States: IDLE, CALC, FIN.
- IDLE, start_i=1 and kill_i=0: latch op, operands and the sign flags; compute absolute values for DIV/REM.
  - Divisor == 0 or signed overflow: go to FIN with the special result preloaded.
  - Otherwise: go to CALC with the counter at XLEN-1 and the partial remainder at 0.
- CALC: one restoring step per cycle.
  - rem = {rem[XLEN-2:0], quo[XLEN-1]}; quo shifts left.
  - If rem >= |divisor|: rem -= |divisor| and quo[0]=1.
  - Counter decrements; when counter == 0 and the step completes, go to FIN.
  - CALC lasts exactly XLEN cycles.
- FIN, one cycle: done_o=1, result_o updated, then go to IDLE.
  - Sign fix: quotient negated when sign(dividend) != sign(divisor) (signed ops only); remainder takes the dividend's sign.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
- Latency, with start sampled at edge 0:
  - Normal case: done_o high in cycle XLEN+1 (cycle 33 for XLEN=32).
  - Special case: done_o high in cycle 1.
- busy_o is high from cycle 1 through the done cycle inclusive. It is low in the cycle start is presented.
- Divide by zero, per the RISC-V spec: quotient = all ones; remainder = dividend unchanged; applies to signed and unsigned ops.
- Signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF, DIV/REM only): quotient=0x80000000, remainder=0.
- Divisor==0 takes precedence over the overflow check.
- start_i while busy: ignored; no queuing, and in-flight operands are unchanged.
- kill_i in any non-IDLE state: go to IDLE at the next edge.
  - No done_o pulse.
  - result_o keeps its previous value.
  - kill has priority over FIN completing in the same cycle.
- kill_i and start_i both high in IDLE: start is ignored.
- done_o is never high for two consecutive cycles.
- A new start may be presented in the cycle after done (back-to-back operations).
- Arithmetic width:
  - Partial remainder is XLEN+1 bits internally so the compare/subtract carries no overflow.
  - Negation is two's complement within XLEN bits; |0x80000000| = 0x80000000, treated as unsigned.

Decomposition:
- Shared Verilog header with the rest of the core (the ALU_OP defines live there):
  - DIV_OP_DIV/DIVU/REM/REMU encodings, 2'b00..2'b11.
  - State encodings DIV_ST_IDLE/CALC/FIN.
- The OPCODE_OP M-extension decode adds an is_div flag plus funct3[1:0] pass-through; no new ALU_OP codes are needed.
- One natural sub-module: div_sign_fix.
  - Combinational.
  - Inputs: raw quotient, raw remainder, sign flags, op.
  - Output: final result.
- The FSM, counter and datapath stay in div_unit.

Test Plan:
- DIV 0xFFFFFFF9 (-7) / 0x00000002, start at cycle 0 -> busy_o=1 in cycles 1..33; done_o only in cycle 33; result_o=0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1).
- DIVU 0xFFFFFFFF / 0x00000002 -> 0x7FFFFFFF; REMU with the same operands -> 0x00000001; both with 33-cycle latency.
- DIV 0x00001234 / 0 -> done in cycle 1, result 0xFFFFFFFF. REMU 0x00001234 / 0 -> 0x00001234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- Start DIVU 100/7; assert kill_i in cycle 10 -> busy_o=0 from cycle 11; no done_o; result_o unchanged. New start DIVU 100/7 at cycle 12 -> done in cycle 45, result 14. REMU 100/7 -> 2.
- Start DIV 50/5, then pulse start_i with 9/3 in cycle 5 while busy -> ignored; result 10 at cycle 33. Next start in cycle 34 -> accepted.
- Deassert rst_n asynchronously mid-CALC (cycle 20) -> busy_o, done_o and result_o go to 0 immediately, without a clock edge. After release, an operation completes normally.
